audio_dac_serializer: RTL

Serializes signed stereo audio samples into an I2S bit stream for the DE2 WM8731 codec DAC. It is the output-side counterpart to the ADC deserializer and filter chain, and consumes filtered samples such as those from the average filter. The block generates BCLK and DACLRCK as codec master and shifts out DACDAT. A one-deep holding buffer with a valid/ready handshake decouples the sample producer from frame timing.

---
 rtl/audio_dac_serializer.sv | 124 ++++++++++++
 1 files changed

// File: rtl/audio_dac_serializer.sv
// I2S serializer for the WM8731 DAC: generates BCLK/DACLRCK as master and shifts out
// signed stereo samples MSB first. A one-deep valid/ready holding buffer feeds each frame.
module audio_dac_serializer #(
    parameter int AUDIO_DATA_WIDTH = 24,
    parameter int BITS_PER_CHANNEL = 32,
    parameter int BCLK_DIV         = 8
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic signed [AUDIO_DATA_WIDTH-1:0] left_in,
    input  logic signed [AUDIO_DATA_WIDTH-1:0] right_in,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic                               aud_bclk,
    output logic                               aud_daclrck,
    output logic                               aud_dacdat,
    output logic                               underrun
);

    localparam int FRAME_BITS = 2 * BITS_PER_CHANNEL;
    localparam int DIV_W      = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BCLK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_RIGHT = CNT_W'(BITS_PER_CHANNEL);

    logic [DIV_W-1:0]                  div_cnt;
    logic [CNT_W-1:0]                  bit_cnt;
    logic                              hold_full;
    logic signed [AUDIO_DATA_WIDTH-1:0] hold_left;
    logic signed [AUDIO_DATA_WIDTH-1:0] hold_right;
    logic signed [AUDIO_DATA_WIDTH-1:0] shift_left;
    logic signed [AUDIO_DATA_WIDTH-1:0] shift_right;

    logic             div_wrap;
    logic             bclk_fall;
    logic [CNT_W-1:0] bit_cnt_next;
    logic             frame_start;
    logic             xfer;
    logic             lrck_next;
    int               slot;
    logic             dat_next;
    logic             hold_full_d;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        div_wrap     = (div_cnt == DIV_LAST);
        bclk_fall    = div_wrap && aud_bclk;
        bit_cnt_next = (bit_cnt == CNT_LAST) ? '0 : bit_cnt + 1'b1;
        frame_start  = bclk_fall && (bit_cnt_next == '0);
        xfer         = in_valid && in_ready;
        lrck_next    = (bit_cnt_next >= CNT_RIGHT);
        slot         = int'(bit_cnt_next) % BITS_PER_CHANNEL;

        // Slot 0 is the I2S one-BCLK delay after the LRCK edge; slots past the word pad with 0.
        dat_next = 1'b0;
        for (int i = 0; i < AUDIO_DATA_WIDTH; i++) begin
            if (slot == i + 1) begin
                dat_next = lrck_next ? shift_right[AUDIO_DATA_WIDTH-1-i]
                                     : shift_left[AUDIO_DATA_WIDTH-1-i];
            end
        end

        hold_full_d = hold_full;
        if (frame_start) begin
            hold_full_d = 1'b0;
        end else if (xfer) begin
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            div_cnt     <= '0;
            aud_bclk    <= 1'b0;
            aud_daclrck <= 1'b0;
            aud_dacdat  <= 1'b0;
            bit_cnt     <= CNT_LAST;
            hold_full   <= 1'b0;
            shift_left  <= '0;
            shift_right <= '0;
            underrun    <= 1'b0;
            in_ready    <= 1'b0;
        end else begin
            underrun  <= 1'b0;
            div_cnt   <= div_wrap ? '0 : div_cnt + 1'b1;
            hold_full <= hold_full_d;
            in_ready  <= ~hold_full_d;

            if (div_wrap) begin
                aud_bclk <= ~aud_bclk;
            end

            if (bclk_fall) begin
                bit_cnt     <= bit_cnt_next;
                aud_daclrck <= lrck_next;
                aud_dacdat  <= dat_next;
            end

            if (frame_start) begin
                if (hold_full) begin
                    shift_left  <= hold_left;
                    shift_right <= hold_right;
                end else if (xfer) begin
                    shift_left  <= left_in;
                    shift_right <= right_in;
                end else begin
                    underrun <= 1'b1;
                end
            end
        end
    end

    // NOTE: the holding data registers are not reset; hold_full alone says whether they are meaningful.
    always_ff @(posedge clk) begin
        if (xfer && !frame_start) begin
            hold_left  <= left_in;
            hold_right <= right_in;
        end
    end

endmodule
